// File: rtl/cam_arb_pkg.sv
// Shared types for the CAM arbiter: opcodes, response record and default widths.
package cam_arb_pkg;
  localparam int AW_LOG2 = 5;
  localparam int NR_LOG2 = 2;
  localparam int DATA_W  = 1 << AW_LOG2;
  localparam int NUM_REQ = 1 << NR_LOG2;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_SEARCH = 2'd2,
    OP_RSVD   = 2'd3
  } cam_op_e;

  typedef struct packed {
    logic [NR_LOG2-1:0] id;
    cam_op_e            op;
    logic               hit;
    logic [DATA_W-1:0]  data;
    logic [AW_LOG2-1:0] index;
  } cam_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant of the first request at or after the pointer.
module rr_arbiter #(
  parameter int N_LOG2 = 2,
  localparam int N = 1 << N_LOG2
)(
  input  logic         clk,
  input  logic         reset_i,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  logic [N_LOG2-1:0] ptr, winner, idx;
  logic              found;

  always_comb begin
    grant  = '0;
    winner = ptr;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + N_LOG2'(i);
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i)                ptr <= '0;
    else if (advance && found)  ptr <= winner + N_LOG2'(1);
  end
endmodule

// File: rtl/cam_arbiter.sv
// Shares one single-cycle CAM among N requesters; responses return in grant order
// through a 2-entry FIFO guarded by a credit check.
module cam_arbiter
  import cam_arb_pkg::*;
#(
  parameter int ARRAY_WIDTH_LOG2 = AW_LOG2,
  parameter int NUM_REQ_LOG2     = NR_LOG2,
  localparam int N  = 1 << NUM_REQ_LOG2,
  localparam int DW = 1 << ARRAY_WIDTH_LOG2
)(
  input  logic                                clk,
  input  logic                                reset_i,
  input  logic [N-1:0]                        req_valid_i,
  output logic [N-1:0]                        req_ready_o,
  input  logic [N-1:0][1:0]                   req_op_i,
  input  logic [N-1:0][ARRAY_WIDTH_LOG2-1:0]  req_index_i,
  input  logic [N-1:0][DW-1:0]                req_data_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [NUM_REQ_LOG2-1:0]             rsp_id_o,
  output logic [1:0]                          rsp_op_o,
  output logic                                rsp_hit_o,
  output logic [DW-1:0]                       rsp_data_o,
  output logic [ARRAY_WIDTH_LOG2-1:0]         rsp_index_o,
  output logic                                cam_read_o,
  output logic [ARRAY_WIDTH_LOG2-1:0]         cam_read_index_o,
  output logic                                cam_write_o,
  output logic [ARRAY_WIDTH_LOG2-1:0]         cam_write_index_o,
  output logic [DW-1:0]                       cam_write_data_o,
  output logic                                cam_search_o,
  output logic [DW-1:0]                       cam_search_data_o,
  input  logic                                cam_read_valid_i,
  input  logic [DW-1:0]                       cam_read_value_i,
  input  logic                                cam_search_valid_i,
  input  logic [ARRAY_WIDTH_LOG2-1:0]         cam_search_index_i
);
  logic [N-1:0]            req_elig, grant;
  logic [NUM_REQ_LOG2-1:0] win_id, infl_id;
  cam_op_e                 win_op, infl_op;
  logic                    issue, infl_vld, pop, credit_ok;
  logic [2:0]              outstanding;
  cam_rsp_t                fifo [2];
  cam_rsp_t                rsp_new, rsp_out;
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;

  // Credits count both the in-flight op and queued responses; a pop this cycle frees one.
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign outstanding = 3'(count) + 3'(infl_vld);
  assign credit_ok   = (outstanding - 3'(pop)) < 3'd2;

  always_comb begin
    req_elig = '0;
    for (int k = 0; k < N; k++)
      req_elig[k] = req_valid_i[k] && (cam_op_e'(req_op_i[k]) != OP_RSVD) && credit_ok && !reset_i;
  end

  rr_arbiter #(.N_LOG2(NUM_REQ_LOG2)) u_rr (
    .clk     (clk),
    .reset_i (reset_i),
    .req     (req_elig),
    .advance (issue),
    .grant   (grant)
  );

  always_comb begin
    win_id = '0;
    for (int k = 0; k < N; k++)
      if (grant[k]) win_id = NUM_REQ_LOG2'(k);
  end

  assign issue             = |grant;
  assign win_op            = cam_op_e'(req_op_i[win_id]);
  assign req_ready_o       = grant;
  assign cam_read_o        = issue && (win_op == OP_READ);
  assign cam_write_o       = issue && (win_op == OP_WRITE);
  assign cam_search_o      = issue && (win_op == OP_SEARCH);
  assign cam_read_index_o  = cam_read_o   ? req_index_i[win_id] : '0;
  assign cam_write_index_o = cam_write_o  ? req_index_i[win_id] : '0;
  assign cam_write_data_o  = cam_write_o  ? req_data_i[win_id]  : '0;
  assign cam_search_data_o = cam_search_o ? req_data_i[win_id]  : '0;

  always_comb begin
    rsp_new    = '0;
    rsp_new.id = infl_id;
    rsp_new.op = infl_op;
    case (infl_op)
      OP_READ: begin
        rsp_new.hit  = cam_read_valid_i;
        rsp_new.data = cam_read_value_i;
      end
      OP_WRITE:  rsp_new.hit = 1'b1;
      OP_SEARCH: begin
        rsp_new.hit   = cam_search_valid_i;
        rsp_new.index = cam_search_index_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      infl_vld <= 1'b0;
      infl_id  <= '0;
      infl_op  <= OP_READ;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else begin
      infl_vld <= issue;
      if (issue) begin
        infl_id <= win_id;
        infl_op <= win_op;
      end
      if (infl_vld) begin
        fifo[wr_ptr] <= rsp_new;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(infl_vld) - 2'(pop);
    end
  end

  assign rsp_valid_o = (count != 2'd0);
  assign rsp_out     = rsp_valid_o ? fifo[rd_ptr] : '0;
  assign rsp_id_o    = rsp_out.id;
  assign rsp_op_o    = rsp_out.op;
  assign rsp_hit_o   = rsp_out.hit;
  assign rsp_data_o  = rsp_out.data;
  assign rsp_index_o = rsp_out.index;
endmodule

// File: tb/tb_cam_arbiter.sv
// Randomized + directed bench for cam_arbiter with a CAM model and a scoreboard.
module tb_cam_arbiter;
  localparam int N = 4, AW = 5, DW = 32;

  logic                  clk = 1'b0;
  logic                  reset_i = 1'b1;
  logic [N-1:0]          req_valid_i = '0, req_ready_o;
  logic [N-1:0][1:0]     req_op_i = '0;
  logic [N-1:0][AW-1:0]  req_index_i = '0;
  logic [N-1:0][DW-1:0]  req_data_i = '0;
  logic                  rsp_valid_o, rsp_ready_i = 1'b1, rsp_hit_o;
  logic [1:0]            rsp_id_o, rsp_op_o;
  logic [DW-1:0]         rsp_data_o;
  logic [AW-1:0]         rsp_index_o;
  logic                  cam_read_o, cam_write_o, cam_search_o;
  logic [AW-1:0]         cam_read_index_o, cam_write_index_o;
  logic [DW-1:0]         cam_write_data_o, cam_search_data_o;
  logic                  cam_read_valid_i = 1'b0, cam_search_valid_i = 1'b0;
  logic [DW-1:0]         cam_read_value_i = '0;
  logic [AW-1:0]         cam_search_index_i = '0;

  always #5 clk = ~clk;

  cam_arbiter #(.ARRAY_WIDTH_LOG2(AW), .NUM_REQ_LOG2(2)) dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_op_o(rsp_op_o), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o), .rsp_index_o(rsp_index_o),
    .cam_read_o(cam_read_o), .cam_read_index_o(cam_read_index_o),
    .cam_write_o(cam_write_o), .cam_write_index_o(cam_write_index_o), .cam_write_data_o(cam_write_data_o),
    .cam_search_o(cam_search_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
  );

  // CAM environment model: one-cycle latency, lowest matching index wins a search.
  logic [DW-1:0] cmem [32];
  bit            cv   [32];
  always @(posedge clk) begin : cam_model
    logic          sh;
    logic [AW-1:0] si;
    sh = 1'b0; si = '0;
    for (int i = 31; i >= 0; i--)
      if (cv[i] && cmem[i] == cam_search_data_o) begin sh = 1'b1; si = AW'(i); end
    cam_read_valid_i   <= cam_read_o && cv[cam_read_index_o];
    cam_read_value_i   <= (cam_read_o && cv[cam_read_index_o]) ? cmem[cam_read_index_o] : '0;
    cam_search_valid_i <= cam_search_o && sh;
    cam_search_index_i <= (cam_search_o && sh) ? si : '0;
    if (cam_write_o) begin
      cmem[cam_write_index_o] <= cam_write_data_o;
      cv[cam_write_index_o]   <= 1'b1;
    end
  end

  // Reference contents, updated in grant order.
  logic [DW-1:0] ref_mem [32];
  bit            ref_v   [32];

  typedef struct { int id; int op; bit hit; logic [DW-1:0] data; int index; int gcyc; } exp_t;
  typedef struct { int op; int idx; logic [DW-1:0] data; } item_t;
  exp_t  sb [$];
  item_t pend [N][$];
  int    gorder [$], gcycs [$], rorder [$], pcycs [$];

  int errors = 0, checks = 0, cyc = 0, ptr_m = 0, gcount = 0, pops = 0;
  int last_lat, last_id, last_op, last_index;
  bit last_hit;
  logic [DW-1:0] last_data;
  bit rand_drop = 0, rand_idle = 0, rdy_rand = 0, rdy_hold = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: predicts grants from round-robin + credit rules, checks CAM bus and responses.
  bit was_reset = 0, prev_hold = 0;
  logic [63:0] prev_rsp;
  always @(negedge clk) begin : monitor
    bit            pop_now, allowed, hit;
    int            exp_k, k, op, idx, index;
    logic [N-1:0]  exp_g;
    logic [DW-1:0] d, rdata;
    logic [76:0]   exp_cam;
    exp_t          e;
    if (reset_i) begin
      chk("reset_ready", req_ready_o, 0);
      chk("reset_strobes", {cam_read_o, cam_write_o, cam_search_o}, 0);
      sb.delete(); ptr_m = 0; was_reset = 1; prev_hold = 0;
    end else begin
      if (was_reset) begin
        chk("post_reset_rsp", {rsp_valid_o, rsp_id_o, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o}, 0);
        was_reset = 0;
      end
      if (prev_hold)
        chk("rsp_stable", {rsp_id_o, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o}, prev_rsp);
      prev_hold = rsp_valid_o && !rsp_ready_i;
      prev_rsp  = 64'({rsp_id_o, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o});
      pop_now = rsp_valid_o && rsp_ready_i;
      allowed = (sb.size() - int'(pop_now)) < 2;
      exp_k = -1;
      if (allowed)
        for (int i = 0; i < N; i++) begin
          k = (ptr_m + i) % N;
          if (exp_k < 0 && req_valid_i[k] && req_op_i[k] != 2'd3) exp_k = k;
        end
      exp_g = (exp_k >= 0) ? N'(1 << exp_k) : '0;
      chk("grant", req_ready_o, exp_g);
      if (pop_now) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid_o, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_fields", {rsp_id_o, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o},
              {2'(e.id), 2'(e.op), e.hit, e.data, 5'(e.index)});
          chk("rsp_latency_min", (cyc - e.gcyc) >= 2, 1);
          last_lat = cyc - e.gcyc; last_id = rsp_id_o; last_op = rsp_op_o;
          last_hit = rsp_hit_o; last_data = rsp_data_o; last_index = rsp_index_o;
          rorder.push_back(rsp_id_o); pcycs.push_back(cyc); pops++;
        end
      end
      exp_cam = '0;
      if (exp_k >= 0) begin
        op = req_op_i[exp_k]; idx = req_index_i[exp_k]; d = req_data_i[exp_k];
        hit = 0; rdata = '0; index = 0;
        case (op)
          0: begin
            exp_cam = {1'b1, 5'(idx), 1'b0, 5'd0, 32'd0, 1'b0, 32'd0};
            hit = ref_v[idx]; rdata = hit ? ref_mem[idx] : '0;
          end
          1: begin
            exp_cam = {1'b0, 5'd0, 1'b1, 5'(idx), d, 1'b0, 32'd0};
            hit = 1; ref_mem[idx] = d; ref_v[idx] = 1;
          end
          default: begin
            exp_cam = {1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, d};
            for (int i = 0; i < 32; i++)
              if (!hit && ref_v[i] && ref_mem[i] == d) begin hit = 1; index = i; end
          end
        endcase
        sb.push_back('{id: exp_k, op: op, hit: hit, data: rdata, index: index, gcyc: cyc});
        gorder.push_back(exp_k); gcycs.push_back(cyc);
        ptr_m = (exp_k + 1) % N; gcount++;
      end
      chk("cam_bus", {cam_read_o, cam_read_index_o, cam_write_o, cam_write_index_o,
                      cam_write_data_o, cam_search_o, cam_search_data_o}, exp_cam);
    end
  end

  // One cycle of stimulus: retire transferred items, present the next ones.
  task automatic tick();
    logic [N-1:0] xfer;
    @(negedge clk);
    xfer = req_valid_i & req_ready_o;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (xfer[k] && pend[k].size() > 0) void'(pend[k].pop_front());
      if (pend[k].size() > 0 && !(rand_drop && $urandom_range(0, 3) == 0)) begin
        req_valid_i[k] = 1'b1; req_op_i[k] = 2'(pend[k][0].op);
        req_index_i[k] = AW'(pend[k][0].idx); req_data_i[k] = pend[k][0].data;
      end else if (rand_idle && $urandom_range(0, 1) == 1) begin
        req_valid_i[k] = 1'b1; req_op_i[k] = 2'd3;
        req_index_i[k] = AW'($urandom); req_data_i[k] = $urandom;
      end else begin
        req_valid_i[k] = 1'b0; req_op_i[k] = '0; req_index_i[k] = '0; req_data_i[k] = '0;
      end
    end
    rsp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
  endtask

  function automatic bit busy();
    bit b = (sb.size() != 0) || rsp_valid_o;
    for (int k = 0; k < N; k++) if (pend[k].size() != 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int lim);
    int n = 0;
    tick();
    while (busy() && n < lim) begin tick(); n++; end
    chk("drain_done", busy(), 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic push(input int k, input int op, input int idx, input logic [DW-1:0] d);
    pend[k].push_back('{op: op, idx: idx, data: d});
  endtask

  initial begin
    int g0, p0, n;
    for (int i = 0; i < 32; i++) begin cv[i] = 0; ref_v[i] = 0; cmem[i] = '0; ref_mem[i] = '0; end
    tick(); tick(); tick();
    reset_i = 1'b0;

    // single write, fixed 2-cycle response latency
    push(0, 1, 1, 32'h1);
    drain(20);
    chk("t1_latency", last_lat, 2);
    chk("t1_rsp", {last_id, last_op, last_hit}, {32'd0, 32'd1, 1'b1});

    // contention: reset puts the pointer at 0, then 0,1,2,3,0,... one per cycle
    do_reset();
    gorder.delete(); gcycs.delete(); rorder.delete(); pcycs.delete();
    for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push(k, 0, k, '0);
    drain(40);
    for (int i = 0; i < 8; i++) begin
      chk("t2_grant_order", gorder[i], i % N);
      chk("t2_rsp_order", rorder[i], i % N);
    end
    chk("t2_grant_span", gcycs[7] - gcycs[0], 7);
    chk("t2_rsp_span", pcycs[7] - pcycs[0], 7);

    // search after write
    push(1, 1, 5, 32'h5);
    push(2, 2, 0, 32'h5);
    drain(20);
    chk("t3_search", {last_id, last_hit, last_index}, {32'd2, 1'b1, 32'd5});

    // read miss
    push(3, 0, 4, '0);
    drain(20);
    chk("t4_miss", {last_hit, last_data}, {1'b0, 32'd0});

    // backpressure: only two ops may be outstanding
    rdy_hold = 0; g0 = gcount; p0 = pops;
    for (int k = 0; k < N; k++) push(k, 0, k, '0);
    repeat (6) tick();
    chk("t5_bp_grants", gcount - g0, 2);
    chk("t5_bp_ready", req_ready_o, 0);
    rdy_hold = 1;
    drain(40);
    chk("t5_total", {gcount - g0, pops - p0}, {32'd4, 32'd4});

    // reset the cycle after a search grant: no response, pointer back to 0
    g0 = gcount; n = 0;
    push(2, 2, 0, 32'h5);
    while (gcount == g0 && n < 20) begin tick(); n++; end
    chk("t6_granted", gcount - g0, 1);
    reset_i = 1'b1;
    p0 = pops;
    tick(); tick();
    reset_i = 1'b0;
    repeat (3) tick();
    chk("t6_no_rsp", pops - p0, 0);
    gorder.delete();
    for (int k = 0; k < N; k++) push(k, 0, k, '0);
    drain(40);
    chk("t6_ptr_zero", gorder[0], 0);

    // randomized traffic with valid drops, reserved opcodes and random backpressure
    rand_drop = 1; rand_idle = 1; rdy_rand = 1;
    for (int i = 0; i < 200; i++)
      push($urandom_range(0, N - 1), $urandom_range(0, 2), $urandom_range(0, 7), DW'($urandom_range(0, 3)));
    drain(4000);
    rand_drop = 0; rand_idle = 0; rdy_rand = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_arbiter.md
# cam_arbiter

Round-robin scheduler that shares one `cam` instance among several requesters. Each requester issues read, write or search operations over a valid/ready handshake. The arbiter grants at most one operation per cycle and drives the CAM's read, write and search strobes exclusively. It returns each CAM result through a tagged, back-pressurable response port that carries the originating requester ID.

## Interface
- `ARRAY_WIDTH_LOG2`, default 5: CAM index width; data width is 2**ARRAY_WIDTH_LOG2 (32).
- `NUM_REQ_LOG2`, default 2: log2 of requester count; N = 2**NUM_REQ_LOG2 (4).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in N: per-requester request valid.
- `req_ready_o` out N: per-requester grant; a transfer occurs when valid && ready. At most one bit is high.
- `req_op_i` in N×2: cam_op_e per requester.
- `req_index_i` in N×ARRAY_WIDTH_LOG2: read or write index.
- `req_data_i` in N×2**ARRAY_WIDTH_LOG2: write data or search key.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_id_o` out NUM_REQ_LOG2: originating requester.
- `rsp_op_o` out 2: operation being answered.
- `rsp_hit_o` out 1: read_valid for READ, search_valid for SEARCH, 1 for WRITE.
- `rsp_data_o` out 2**ARRAY_WIDTH_LOG2: read value for READ, 0 otherwise.
- `rsp_index_o` out ARRAY_WIDTH_LOG2: search index for SEARCH, 0 otherwise.
- CAM side:
  - outputs `cam_read_o`, `cam_read_index_o`, `cam_write_o`, `cam_write_index_o`, `cam_write_data_o`, `cam_search_o`, `cam_search_data_o`
  - inputs `cam_read_valid_i`, `cam_read_value_i`, `cam_search_valid_i`, `cam_search_index_i`

## Operation
- Opcodes:
  - OP_READ = 0, OP_WRITE = 1, OP_SEARCH = 2.
  - OP_RSVD = 3 is never granted. Its requester's ready stays low, and it is skipped during arbitration.
- Round-robin:
  - A priority pointer names the highest-priority requester. Reset value is 0.
  - After a grant to requester k, the pointer becomes (k+1) mod N.
  - Without a grant the pointer holds.
- Issue:
  - In the grant cycle, exactly one of the `cam_*_o` strobes is asserted and the matching index/data fields are driven from the winner.
  - Unused CAM fields are driven to 0. No strobe is asserted in a cycle without a grant.
- In-flight tag: register {valid, id, op} captured at the grant edge.
- Response FIFO:
  - 2 entries.
  - Loaded one cycle after issue, from the CAM outputs and the in-flight tag.
- Credits:
  - outstanding = in-flight valid + FIFO occupancy.
  - A grant is allowed only if outstanding − (rsp_valid_o && rsp_ready_i) < 2.
  - This keeps FIFO overflow impossible.
- Ordering: responses leave in grant order. The CAM resolves write-then-search ordering because the arbiter issues strictly sequentially.

## Timing
- CAM latency is fixed at 1 cycle: the request strobe in cycle t gives valid results in cycle t+1.
- Grant cycle t: `req_ready_o[k]` = 1 and CAM strobes are active. The response is visible at `rsp_*_o` in cycle t+2 at the earliest.
- Throughput is one operation per cycle while `rsp_ready_i` is held high.
- If `rsp_ready_i` is low for ≥2 cycles, grants stop after 2 outstanding operations. They resume in the same cycle `rsp_ready_i` pops an entry.
- `rsp_*_o` are stable while rsp_valid_o && !rsp_ready_i.
- Reset values:
  - `req_ready_o` = 0 and all `cam_*_o` = 0.
  - `rsp_valid_o` = 0 and all `rsp_*` data/tag = 0.
  - Pointer = 0, FIFO empty, in-flight invalid.
- Reset mid-operation: the in-flight operation and all FIFO entries are dropped with no response. A write already strobed to the CAM is not retracted.
- A requester dropping valid before it sees ready is legal; no operation is issued for it.

## Structure
- Package `cam_arb_pkg`:
  - cam_op_e enum.
  - packed struct cam_rsp_t {id, op, hit, data, index}.
  - Width localparams derived from ARRAY_WIDTH_LOG2 and NUM_REQ_LOG2.
- Sub-module `rr_arbiter`:
  - Ports: N-bit request in, N-bit one-hot grant out, advance strobe.
  - Holds the rotating priority pointer.
- The response FIFO and credit logic stay inline in `cam_arbiter`.

## Test plan
- Reset and single write:
  - Stimulus: after reset, req0 WRITE idx 1, data 32'h1.
  - Required: `cam_write_o` = 1 with idx 1 in the grant cycle; 2 cycles later a response with id 0, op WRITE, hit 1.
- Contention:
  - Stimulus: req0–req3 all valid with READ each cycle.
  - Required: grants in order 0,1,2,3,0; responses carry ids in the same order, one per cycle.
- Search after write:
  - Stimulus: req1 WRITE idx 5, data 32'h5; next cycle req2 SEARCH 32'h5.
  - Required: req2's response has hit 1, index 5.
- Read miss:
  - Stimulus: READ of unwritten idx 4.
  - Required: hit 0, data 0.
- Backpressure:
  - Stimulus: `rsp_ready_i` = 0 while 4 READs are pending.
  - Required: exactly 2 grants, then `req_ready_o` = 0. Raising ready drains the 2 responses, and the remaining grants follow with no loss or duplication.
- Reset mid-flight:
  - Stimulus: assert `reset_i` the cycle after a SEARCH grant.
  - Required: no response for it; all outputs at reset values; pointer 0.
